// File: rtl/lib_decmps_to_pow2_seq_if.sv
// Handshake bundle for lib_decmps_to_pow2_seq: vector in, one-hot beats out.
// master = producer/consumer side, slave = the decomposer.
interface lib_decmps_to_pow2_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
  logic             vect_vld;
  logic [WIDTH-1:0] vect;
  logic             vect_rdy;
  logic             out_vld;
  logic [WIDTH-1:0] onehot [LANES-1:0];
  logic [LANES-1:0] lane_vld;
  logic             out_last;
  logic             out_rdy;
  logic [CNT_W-1:0] res_cnt;

  modport master (
    output vect_vld, vect, out_rdy,
    input  vect_rdy, out_vld, onehot, lane_vld, out_last, res_cnt
  );

  modport slave (
    input  vect_vld, vect, out_rdy,
    output vect_rdy, out_vld, onehot, lane_vld, out_last, res_cnt
  );
endinterface

// File: rtl/lib_decmps_to_pow2_seq.sv
// Sequential bit-mask decomposer: emits set bits of a latched vector as one-hot words,
// up to LANES per beat. Define LIB_DECMPS_TO_POW2_SEQ_B2B_EN for bubble-free back-to-back loads.
module lib_decmps_to_pow2_seq #(
  parameter int unsigned LSB_MSB = 0,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LANES   = 2,
  parameter int unsigned CNT_W   = $clog2(WIDTH + 1)
) (
  input logic                     clk,
  input logic                     rst,
  lib_decmps_to_pow2_seq_if.slave bus
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] lane_word [LANES-1:0];
  logic [WIDTH-1:0] emit_mask;
  logic [CNT_W-1:0] pop;
  logic             busy;
  logic             last;
  logic             xfer;
  logic             accept;

  // Each stage takes the first set bit of what the previous stages left behind.
  always_comb begin : ffs_cascade
    logic [WIDTH-1:0] rem;
    rem       = res_q;
    emit_mask = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      lane_word[k] = '0;
      // Scan from lowest to highest priority so the last hit is the winner.
      for (int j = 0; j < int'(WIDTH); j++) begin
        if (rem[(LSB_MSB != 0) ? j : (int'(WIDTH) - 1 - j)]) begin
          lane_word[k] = '0;
          lane_word[k][(LSB_MSB != 0) ? j : (int'(WIDTH) - 1 - j)] = 1'b1;
        end
      end
      rem       = rem & ~lane_word[k];
      emit_mask = emit_mask | lane_word[k];
    end
  end

  always_comb begin : popcount
    pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop = pop + CNT_W'(res_q[i]);
    end
  end

  assign busy = (state_q == StBusy);
  assign last = (int'(pop) <= int'(LANES));
  assign xfer = busy && bus.out_rdy;

`ifdef LIB_DECMPS_TO_POW2_SEQ_B2B_EN
  assign bus.vect_rdy = !busy || (xfer && last);
`else
  assign bus.vect_rdy = !busy;
`endif

  assign accept       = bus.vect_vld && bus.vect_rdy;
  assign bus.out_vld  = busy;
  assign bus.out_last = busy && last;
  assign bus.res_cnt  = pop;

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    assign bus.onehot[k]   = lane_word[k];
    assign bus.lane_vld[k] = (int'(pop) > k);
  end

  // Accept takes priority so a back-to-back load replaces the final beat's residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      res_q   <= '0;
    end else if (accept) begin
      state_q <= StBusy;
      res_q   <= bus.vect;
    end else if (xfer) begin
      if (last) begin
        state_q <= StIdle;
        res_q   <= '0;
      end else begin
        res_q <= res_q & ~emit_mask;
      end
    end
  end

endmodule

// File: doc/lib_decmps_to_pow2_seq.md
Name: lib_decmps_to_pow2_seq

Overview:
- Sequential, flow-controlled successor of the one-hot decomposer.
- Latches a WIDTH-bit vector and emits its set bits as one-hot words, up to LANES per beat, over as many beats as needed.
- Uses valid/ready handshakes on both sides.
- Sits between a bit-mask producer (e.g. error-locator/erasure masks) and per-position consumers that cannot take the whole mask in one cycle.

Parameters:
- LSB_MSB, 0, priority order: 0 = lowest set bit first, 1 = highest set bit first.
- WIDTH, 8, input vector width; must be >= 1.
- LANES, 2, one-hot words per output beat; 1 <= LANES <= WIDTH.
- CNT_W, $clog2(WIDTH+1), width of the residual bit-count output.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- vect_vld  input  1  input vector valid.
- vect  input  WIDTH  vector to decompose.
- vect_rdy  output  1  block can accept a vector.
- out_vld  output  1  output beat valid.
- onehot  output  WIDTH x LANES (unpacked [LANES-1:0])  one-hot words; lane 0 carries the highest-priority bit.
- lane_vld  output  LANES  per-lane valid mask, contiguous from lane 0.
- out_last  output  1  final beat of the current vector.
- out_rdy  input  1  downstream accepts the beat.
- res_cnt  output  CNT_W  set bits still pending in the residue, including the current beat.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State IDLE, residue 0.
  - vect_rdy=1, out_vld=0, out_last=0, lane_vld=0, res_cnt=0.
  - All onehot words 0.
- States:
  - IDLE: vect_rdy=1, out_vld=0.
  - BUSY: vect_rdy=0, out_vld=1.
- Input accept:
  - Condition: vect_vld && vect_rdy.
  - Loads the residue register with vect and moves to BUSY.
  - First beat appears on the next cycle (latency 1).
- Output beat generation (BUSY):
  - Derived combinationally from the residue by LANES cascaded find-first-set stages in LSB_MSB order.
  - Lane k holds the k-th set bit of the residue, or 0 if fewer than k+1 bits remain.
  - lane_vld[k] = (popcount(residue) > k).
- Zero vector: exactly one beat is emitted, with lane_vld=0, all onehot=0, out_last=1, res_cnt=0.
- out_last = (popcount(residue) <= LANES).
- Beat transfer (out_vld && out_rdy):
  - The residue clears every bit emitted in that beat.
  - If out_last, the block returns to IDLE and the residue becomes 0.
- Backpressure: while out_vld && !out_rdy, all outputs and the residue hold stable. No bit is dropped or duplicated.
- Input while BUSY: vect_vld is ignored and vect_rdy=0. The producer must hold vect.
- rst mid-operation: the residue is discarded and all outputs return to reset values next cycle. No partial beat is issued afterwards.
- Invariants:
  - The OR of all emitted onehot words over a vector equals vect.
  - Emitted words are pairwise disjoint.
  - The number of beats is max(1, ceil(popcount(vect)/LANES)).

Optional Feature:
- Macro: LIB_DECMPS_TO_POW2_SEQ_B2B_EN.
- When defined:
  - vect_rdy is also high in BUSY during the cycle where out_vld && out_rdy && out_last.
  - An accept in that cycle loads the new vector directly, and the state stays BUSY.
  - Sustains one vector per beat-sequence with zero bubble cycles.
- When undefined: a vector is accepted only in IDLE, giving one idle cycle between vectors.

Test Plan:
- LSB first: WIDTH=8, LANES=2, LSB_MSB=0, vect=8'hB5, out_rdy=1.
  - Beat 1: onehot={01,04}, lane_vld=2'b11, res_cnt=5.
  - Beat 2: onehot={10,20}, lane_vld=2'b11, res_cnt=3.
  - Beat 3: onehot={80,00}, lane_vld=2'b01, out_last=1, res_cnt=1.
  - Then IDLE.
- MSB first: same settings with LSB_MSB=1, vect=8'hB5 -> beats {80,20}, {10,04}, {01,00} with last=1 on beat 3.
- Zero and full vectors:
  - vect=8'h00 -> single beat: lane_vld=00, out_last=1, res_cnt=0; vect_rdy returns 1 the cycle after.
  - vect=8'hFF with LANES=8 -> one beat carrying all eight one-hots, out_last=1.
- Backpressure and input stability:
  - vect=8'h06, out_rdy held low 3 cycles -> onehot={02,04} stable for all 3 cycles, released on the 4th.
  - vect_vld pulses during BUSY are ignored.
- Reset mid-operation: assert rst during beat 2 of 8'hB5 -> next cycle out_vld=0, vect_rdy=1, res_cnt=0. A following vect=8'h01 gives a single beat {01,00} with last=1.
- Back-to-back, with B2B_EN defined: vect=8'h03 then vect=8'h0C presented continuously with out_rdy=1.
  - Beats {01,02} and {04,08} arrive on consecutive cycles, with no out_vld gap.
  - Without the macro, a 1-cycle gap appears.
